div_unit_32bit: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/div_unit_32bit.sv | 151 +++++++++++++++
 tb/tb_div_unit_32bit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_32bit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Sign-magnitude in, unsigned shift/subtract core, sign fix-up before the result register.
module div_unit_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic             is_signed;
    logic [WIDTH-1:0] abs_a, abs_b, min_val, diff;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        is_signed = ~op_i[0];
        min_val   = {1'b1, {(WIDTH-1){1'b0}}};
        abs_a     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;

        // Shifted partial remainder needs WIDTH+1 bits for unsigned divisors near 2^WIDTH;
        // when it fits, the difference is always below the divisor so WIDTH bits suffice.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        diff   = rem_sh[WIDTH-1:0] - dvs_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    is_rem_d = op_i[1];
                    qneg_d   = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rneg_d   = is_signed & a_i[WIDTH-1];
                    rem_d    = '0;
                    quo_d    = abs_a;
                    dvs_d    = abs_b;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = CALC;
                    if (b_i == '0) begin
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        quo_d   = '1;
                        rem_d   = a_i;
                        state_d = FIX;
                    end else if (is_signed && a_i == min_val && b_i == '1) begin
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        quo_d   = min_val;
                        rem_d   = '0;
                        state_d = FIX;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? diff : rem_sh[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                result_d = is_rem_q ? (rneg_q ? -rem_q : rem_q)
                                    : (qneg_q ? -quo_q : quo_q);
                state_d  = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (kill_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// Scoreboard bench for div_unit_32bit: directed RV32M corner cases, stall/kill/reset
// scenarios, then randomized back-to-back ops against an independent reference model.
module tb_div_unit_32bit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [31:0] MIN32  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        kill_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] last_result = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } txn_t;

    txn_t sb[$];

    div_unit_32bit #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .kill_i  (kill_i),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .result_o(result_o)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma, mb, q, r;
        sgn = ~op[0];
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == MIN32 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN32;
        ma = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (sgn && a[31]) r = ~r + 32'd1;
        return op[1] ? r : q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int unsigned n;
        txn_t t;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready", {31'd0, ready_o}, 32'd1);
        start_i = 1'b1;
        op_i = op;
        a_i  = a;
        b_i  = b;
        t.op = op; t.a = a; t.b = b; t.exp = exp;
        sb.push_back(t);
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i = 2'($urandom);
        a_i  = $urandom;
        b_i  = $urandom;
    endtask

    // Latency counts edges after the accepting edge: 33 normal (edge 34 counting
    // the accept as edge 1), 1 for special cases (edge 2).
    task automatic collect(input string tag, input int unsigned hold, input bit poke);
        int unsigned n;
        int unsigned lat;
        txn_t t;
        n = 0;
        ready_i = 1'b0;
        while (valid_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        t = sb.pop_front();
        lat = is_special(t.op, t.a, t.b) ? 1 : 33;
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, result_o, t.exp);
        last_result = t.exp;
        for (int i = 0; i < int'(hold); i++) begin
            if (poke) begin
                start_i = 1'b1;
                op_i = 2'($urandom);
                a_i  = $urandom;
                b_i  = $urandom;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            check({tag, "_hold"}, {30'd0, valid_o, ready_o}, 32'd2);
            check({tag, "_hold_res"}, result_o, t.exp);
        end
        ready_i = 1'b1;
        if (poke) start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        ready_i = 1'b0;
        check({tag, "_drop"}, {30'd0, valid_o, ready_o}, 32'd1);
        check({tag, "_keep"}, result_o, t.exp);
    endtask

    initial begin
        int unsigned bad;
        logic [1:0]  op;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        issue(OP_DIV, 32'd100, 32'd7, 32'd14);                     collect("div_100_7", 0, 0);
        issue(OP_REM, 32'd100, 32'd7, 32'd2);                      collect("rem_100_7", 0, 0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);        collect("div_m7_2", 0, 0);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);        collect("rem_m7_2", 0, 0);
        issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1);               collect("remu_fff9_2", 0, 0);
        issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);               collect("divu_5_0", 0, 0);
        issue(OP_REM, 32'd5, 32'd0, 32'd5);                        collect("rem_5_0", 0, 0);
        issue(OP_DIV, MIN32, 32'hFFFF_FFFF, MIN32);                collect("div_min_m1", 0, 0);
        issue(OP_REM, MIN32, 32'hFFFF_FFFF, 32'd0);                collect("rem_min_m1", 0, 0);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);       collect("divu_max_max", 0, 0);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);        collect("div_7_m2", 0, 0);

        // Stall in DONE for 10 cycles with stray start pulses.
        issue(OP_DIV, 32'd1234, 32'd10, 32'd123);                  collect("stall", 10, 1);

        // Kill at CALC cycle 15.
        issue(OP_DIV, 32'd1000, 32'd3, 32'd333);
        repeat (14) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        void'(sb.pop_front());
        check("kill_ready", {31'd0, ready_o}, 32'd1);
        check("kill_valid", {31'd0, valid_o}, 32'd0);
        check("kill_result_kept", result_o, last_result);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0) bad++;
        end
        check("kill_no_valid", bad, 32'd0);
        issue(OP_DIV, 32'd9, 32'd3, 32'd3);                        collect("after_kill", 0, 0);

        // Synchronous reset mid-CALC.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd17, 32'hDEAD_BEEF / 32'd17);
        repeat (10) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        rst_i = 1'b0;
        sb.delete();
        last_result = '0;
        issue(OP_REMU, 32'd1000, 32'd7, 32'd6);                    collect("after_rst", 0, 0);

        // Random back-to-back ops; each new op is issued right as valid_o drops.
        for (int k = 0; k < 1500; k++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MIN32; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'd0 - $urandom_range(1, 15);
                4: a = $urandom_range(0, 255);
                default: ;
            endcase
            issue(op, a, b, ref_div(op, a, b));
            collect("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
